// File: rtl/ghash_controller.sv
// Streaming GHASH engine: accumulates (acc ^ block) * H over a multicycle
// GF(2^128) multiplier and presents the tag on a valid/ready port.

module gf128_multiplier (
  input  logic [127:0] x,
  input  logic [127:0] y,
  output logic [127:0] prod
);
  logic [127:0] w_z;
  logic [127:0] w_v;

  // Right-shift multiply in GCM bit order: bit 127 is the x^0 coefficient.
  always_comb begin
    w_z = '0;
    w_v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) w_z = w_z ^ w_v;
      if (w_v[0]) w_v = (w_v >> 1) ^ {8'he1, 120'h0};
      else        w_v = w_v >> 1;
    end
    prod = w_z;
  end
endmodule

module ghash_controller #(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [127:0]     key,
  output logic             key_ready,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [127:0]     s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [127:0]     m_tag,
  output logic [CNT_W-1:0] m_blocks,
  output logic             busy
);
  typedef enum logic [1:0] {NOKEY, IDLE, MUL, OUT} state_t;

  localparam logic [3:0]       CYC_INIT = 4'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_next;
  logic [127:0]       r_h;
  logic [127:0]       r_acc;
  logic [127:0]       r_op;
  logic [127:0]       r_tag;
  logic               r_last;
  logic [3:0]         r_cyc;
  logic [CNT_W-1:0]   r_blk;
  logic [CNT_W-1:0]   r_blocks;
  logic [127:0]       w_prod;

  gf128_multiplier u_mul (
    .x    (r_op),
    .y    (r_h),
    .prod (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= NOKEY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    key_ready = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    busy      = 1'b0;
    case (r_state)
      NOKEY: begin
        key_ready = 1'b1;
        if (key_load) w_next = IDLE;
      end
      IDLE: begin
        key_ready = 1'b1;
        s_ready   = !key_load;
        if (!key_load && s_valid) w_next = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (r_cyc == 4'd0) w_next = r_last ? OUT : IDLE;
      end
      OUT: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        if (m_ready) w_next = IDLE;
      end
      default: w_next = NOKEY;
    endcase
  end

  // op_q and H are frozen during MUL so the multiplier path may take several cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h      <= '0;
      r_acc    <= '0;
      r_op     <= '0;
      r_tag    <= '0;
      r_last   <= 1'b0;
      r_cyc    <= '0;
      r_blk    <= '0;
      r_blocks <= '0;
    end else begin
      case (r_state)
        NOKEY, IDLE: begin
          if (key_load) begin
            r_h   <= key;
            r_acc <= '0;
            r_blk <= '0;
          end else if (r_state == IDLE && s_valid) begin
            r_op   <= r_acc ^ s_data;
            r_last <= s_last;
            r_cyc  <= CYC_INIT;
            if (r_blk != '1) r_blk <= r_blk + BLK_ONE;
          end
        end
        MUL: begin
          if (r_cyc != 4'd0) begin
            r_cyc <= r_cyc - 4'd1;
          end else begin
            r_acc <= w_prod;
            if (r_last) begin
              r_tag    <= w_prod;
              r_blocks <= r_blk;
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            r_acc <= '0;
            r_blk <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_tag    = r_tag;
  assign m_blocks = r_blocks;
endmodule

// File: tb/tb_ghash_controller.sv
// Scoreboard bench for ghash_controller across MUL_CYCLES = 2, 4, 1, 16.

module tb_ghash_controller;
  localparam logic [127:0] KAT_H = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] KAT_C = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] KAT_T = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] ONE_H = {1'b1, 127'h0};
  localparam logic [127:0] BLK_A = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] BLK_B = 128'hdeadbeefcafef00d_1122334455667788;
  localparam logic [127:0] BLK_C = 128'ha5a5a5a55a5a5a5a_0f0f0f0ff0f0f0f0;
  localparam logic [127:0] BLK_D = 128'h13579bdf2468ace0_0000ffff12345678;
  localparam logic [127:0] BLK_Z = 128'h8899aabbccddeeff_7766554433221100;

  typedef struct {
    int           idx;
    logic [127:0] tag;
    logic [31:0]  blocks;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [3:0]   keyLoad;
  logic [3:0]   keyReady;
  logic [3:0]   sValid;
  logic [3:0]   sReady;
  logic [3:0]   sLast;
  logic [3:0]   mValid;
  logic [3:0]   mReady;
  logic [3:0]   busy;
  logic [127:0] key     [4];
  logic [127:0] sData   [4];
  logic [127:0] mTag    [4];
  logic [31:0]  mBlocks [4];

  exp_t sbQ[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    localparam int MC = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 16;
    ghash_controller #(.MUL_CYCLES(MC), .CNT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_load  (keyLoad[g]),
      .key       (key[g]),
      .key_ready (keyReady[g]),
      .s_valid   (sValid[g]),
      .s_ready   (sReady[g]),
      .s_data    (sData[g]),
      .s_last    (sLast[g]),
      .m_valid   (mValid[g]),
      .m_ready   (mReady[g]),
      .m_tag     (mTag[g]),
      .m_blocks  (mBlocks[g]),
      .busy      (busy[g])
    );
  end

  function automatic int mcOf(int i);
    case (i)
      0: return 2;
      1: return 4;
      2: return 1;
      default: return 16;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every tag handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mValid[i] && mReady[i]) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedTag: dut %0d got %h with no expectation", i, mTag[i]);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("tagDut", 128'(i), 128'(e.idx));
          checkOutput("tag", mTag[i], e.tag);
          checkOutput("blocks", 128'(mBlocks[i]), 128'(e.blocks));
        end
      end
    end
  end

  task automatic expectTag(int i, logic [127:0] t, logic [31:0] n);
    exp_t e;
    e.idx = i;
    e.tag = t;
    e.blocks = n;
    sbQ.push_back(e);
  endtask

  task automatic loadKey(int i, logic [127:0] k);
    keyLoad[i] = 1'b1;
    key[i] = k;
    @(posedge clk);
    #1 keyLoad[i] = 1'b0;
  endtask

  task automatic applyStimulus(int i, logic [127:0] d, logic last);
    int n;
    sValid[i] = 1'b1;
    sData[i] = d;
    sLast[i] = last;
    n = 0;
    @(negedge clk);
    while (!sReady[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sReady[i]) checkOutput("acceptTimeout", 128'(sReady[i]), 128'(1));
    @(posedge clk);
    #1;
    sValid[i] = 1'b0;
    sLast[i] = 1'b0;
  endtask

  // Counts the accept edge plus every edge until m_valid is seen.
  task automatic checkLatency(int i);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!mValid[i] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("tagLatency", 128'(lat), 128'(mcOf(i) + 1));
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 128'(sbQ.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(int i);
    checkOutput("rstSReady", 128'(sReady[i]), 128'(0));
    checkOutput("rstKeyReady", 128'(keyReady[i]), 128'(1));
    checkOutput("rstMValid", 128'(mValid[i]), 128'(0));
    checkOutput("rstBusy", 128'(busy[i]), 128'(0));
    checkOutput("rstTag", mTag[i], 128'(0));
    checkOutput("rstBlocks", 128'(mBlocks[i]), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    keyLoad = '0;
    sValid = '0;
    sLast = '0;
    mReady = '1;
    for (int i = 0; i < 4; i++) begin
      key[i] = '0;
      sData[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) checkResetOutputs(i);
    @(posedge clk);
    #1;

    sValid[0] = 1'b1;
    sData[0] = BLK_A;
    sLast[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("nokeySReady", 128'(sReady[0]), 128'(0));
      checkOutput("nokeyBusy", 128'(busy[0]), 128'(0));
    end
    @(posedge clk);
    #1;
    sValid[0] = 1'b0;
    sLast[0] = 1'b0;

    loadKey(0, KAT_H);
    expectTag(0, KAT_T, 1);
    applyStimulus(0, KAT_C, 1'b1);
    checkLatency(0);
    waitDrain();

    loadKey(0, ONE_H);
    expectTag(0, BLK_A ^ BLK_B ^ BLK_C, 3);
    applyStimulus(0, BLK_A, 1'b0);
    applyStimulus(0, BLK_B, 1'b0);
    applyStimulus(0, BLK_C, 1'b1);
    waitDrain();
    expectTag(0, BLK_D, 1);
    applyStimulus(0, BLK_D, 1'b1);
    waitDrain();

    loadKey(0, KAT_H);
    expectTag(0, 128'h0, 1);
    applyStimulus(0, 128'h0, 1'b1);
    waitDrain();

    keyLoad[0] = 1'b1;
    key[0] = 128'h0;
    sValid[0] = 1'b1;
    sData[0] = BLK_B;
    sLast[0] = 1'b1;
    @(negedge clk);
    checkOutput("keyGatesSReady", 128'(sReady[0]), 128'(0));
    @(posedge clk);
    #1;
    keyLoad[0] = 1'b0;
    sValid[0] = 1'b0;
    sLast[0] = 1'b0;
    @(negedge clk);
    checkOutput("noAcceptOnKey", 128'(busy[0]), 128'(0));
    @(posedge clk);
    #1;
    expectTag(0, 128'h0, 2);
    applyStimulus(0, BLK_A, 1'b0);
    applyStimulus(0, BLK_C, 1'b1);
    waitDrain();

    loadKey(0, KAT_H);
    expectTag(0, KAT_T, 1);
    applyStimulus(0, KAT_C, 1'b1);
    checkOutput("mulKeyReady", 128'(keyReady[0]), 128'(0));
    keyLoad[0] = 1'b1;
    key[0] = ONE_H;
    @(posedge clk);
    #1 keyLoad[0] = 1'b0;
    waitDrain();
    expectTag(0, KAT_T, 1);
    applyStimulus(0, KAT_C, 1'b1);
    waitDrain();

    loadKey(0, ONE_H);
    mReady[0] = 1'b0;
    expectTag(0, BLK_A ^ BLK_B, 2);
    expectTag(0, BLK_Z, 1);
    applyStimulus(0, BLK_A, 1'b0);
    applyStimulus(0, BLK_B, 1'b1);
    checkLatency(0);
    sValid[0] = 1'b1;
    sData[0] = BLK_Z;
    sLast[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("bpValid", 128'(mValid[0]), 128'(1));
      checkOutput("bpTag", mTag[0], BLK_A ^ BLK_B);
      checkOutput("bpBlocks", 128'(mBlocks[0]), 128'(2));
      checkOutput("bpSReady", 128'(sReady[0]), 128'(0));
    end
    @(posedge clk);
    #1 mReady[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("readyAfterOut", 128'(sReady[0]), 128'(1));
    @(posedge clk);
    #1;
    sValid[0] = 1'b0;
    sLast[0] = 1'b0;
    waitDrain();

    loadKey(1, KAT_H);
    expectTag(1, KAT_T, 1);
    applyStimulus(1, KAT_C, 1'b1);
    checkLatency(1);
    waitDrain();
    applyStimulus(1, KAT_C, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetOutputs(1);
    @(posedge clk);
    #1;
    loadKey(1, KAT_H);
    expectTag(1, KAT_T, 1);
    applyStimulus(1, KAT_C, 1'b1);
    checkLatency(1);
    waitDrain();

    for (int i = 2; i < 4; i++) begin
      loadKey(i, KAT_H);
      expectTag(i, KAT_T, 1);
      applyStimulus(i, KAT_C, 1'b1);
      checkLatency(i);
      waitDrain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ghash_controller.md
# ghash_controller

Sequencing controller that wraps one instance of the combinational `gf128_multiplier` and turns it into a streaming GHASH engine for AES-GCM. It holds the hash subkey H and the running accumulator, and feeds `(acc ^ block) · H` through the multiplier once per 128-bit input block. The multiplier is given `MUL_CYCLES` clock cycles as a multicycle path. On the last block of a message, the controller presents the tag on a valid/ready output. It sits between the GCM block formatter (AAD/ciphertext/length blocks) and the tag XOR stage.

## Interface
Parameters:
- `MUL_CYCLES`, default 2: cycles allowed for the multiplier output to settle; legal range 1..16.
- `CNT_W`, default 32: width of the per-message block counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous and active-high.
- `key_load`  in  1  load H from `key` (single-cycle strobe).
- `key`  in  128  hash subkey H, GCM bit order (bit 127 = spec bit 0).
- `key_ready`  out  1  high in states NOKEY and IDLE; `key_load` is honoured only when this is high.
- `s_valid`  in  1  input block valid.
- `s_ready`  out  1  controller can accept a block.
- `s_data`  in  128  input block, GCM bit order.
- `s_last`  in  1  block is the final block of the message (normally the length block).
- `m_valid`  out  1  tag valid.
- `m_ready`  in  1  downstream accepts tag.
- `m_tag`  out  128  GHASH result.
- `m_blocks`  out  CNT_W  number of blocks in the message that produced `m_tag`.
- `busy`  out  1  high in MUL and OUT.

## Operation
- Internal registers: `h_q` (128), `acc` (128), `op_q` (128), `last_q`, `cyc_cnt` (4 bits), `blk_cnt` (CNT_W).
- Multiplier instance connections: `x = op_q`, `y = h_q`. The output `prod` is sampled only as described below.
- FSM states: NOKEY, IDLE, MUL, OUT.
- NOKEY:
  - `s_ready` is 0.
  - `key_load` latches `h_q <= key` and clears `acc` and `blk_cnt`, then goes to IDLE.
- IDLE:
  - `s_ready` is 1 unless `key_load` is high.
  - `key_load` has priority. It reloads `h_q`, clears `acc` and `blk_cnt`, and stays in IDLE. No block is accepted that cycle.
  - On `s_valid && s_ready`:
    - `op_q <= acc ^ s_data`
    - `last_q <= s_last`
    - `cyc_cnt <= MUL_CYCLES-1`
    - `blk_cnt <= blk_cnt + 1`, saturating at all-ones
    - go to MUL.
- MUL:
  - `s_ready` is 0 and `key_load` is ignored.
  - While `cyc_cnt != 0`, decrement it each cycle.
  - When `cyc_cnt == 0`:
    - `acc <= prod`.
    - If `last_q`: `m_tag <= prod`, `m_blocks <= blk_cnt`, go to OUT.
    - Otherwise go to IDLE.
- OUT:
  - `m_valid` is 1; `m_tag` and `m_blocks` are stable.
  - On `m_ready`: clear `acc` and `blk_cnt`, then go to IDLE.
  - `key_load` is ignored in this state.
- `op_q` and `h_q` must not change while in MUL; this guarantees the multicycle path is valid.
- Arithmetic: all combining is XOR over 128 bits. `blk_cnt` saturates and never wraps.
- H = 0 is legal and produces an all-zero tag.

## Timing
- Reset values:
  - state NOKEY
  - `s_ready` 0, `key_ready` 1, `m_valid` 0, `busy` 0
  - `m_tag` 0, `m_blocks` 0
  - `acc`, `op_q`, `h_q`, `blk_cnt`, `cyc_cnt`, `last_q` all 0.
- `rst` asserted in any state returns the FSM to NOKEY on the next edge. Any in-flight message and any pending tag are discarded, and H must be reloaded.
- Block accept to `acc` update takes MUL_CYCLES+1 edges: one edge for the accept, then MUL_CYCLES edges in MUL.
- Throughput is one block per MUL_CYCLES+1 cycles. `s_ready` returns high on the cycle after MUL exits.
- Accepting the last block to `m_valid` rising takes MUL_CYCLES+1 cycles.
- After the OUT handshake, `s_ready` is high on the next cycle.
- `m_valid` holds until `m_ready`. `m_valid` never depends combinationally on `m_ready`.
- `s_ready`, `key_ready`, `m_valid` and `busy` are decoded from state only, except that `s_ready` is also gated by `key_load` in IDLE.
- `s_valid` asserted while `s_ready` is low has no effect; data is not captured.

## Test plan
- **Known-answer, single block.** Reset, `key_load` with H = 66e94bd4ef8a2c3b884cfa59ca342b2e, then send one block 0388dace60b6a392f328c2b971b2fe78 with `s_last` = 1. Required: `m_tag` = 5e2ec746917062882c85b0685353deb7, `m_blocks` = 1, `m_valid` rising exactly MUL_CYCLES+1 cycles after the accept.
- **Identity key, multi-block.** H = 8000…0 (field element 1). Send three blocks A, B, C with last on C. Required: `m_tag` = A^B^C, `m_blocks` = 3. Then send a second message D (last). Required: tag = D, proving `acc` is cleared between messages.
- **Zero cases.** Test H = 0 with any blocks, and any H with a single zero block. In both cases `m_tag` = 0.
- **Backpressure.** Hold `m_ready` low for 10 cycles in OUT. Required: `m_valid`, `m_tag` and `m_blocks` stable, and `s_ready` stays 0. Continuous `s_valid` during OUT accepts nothing until the handshake completes.
- **Key and valid corner cases.**
  - `s_valid` high in NOKEY: no accept.
  - `key_load` and `s_valid` together in IDLE: key reloaded, no accept.
  - `key_load` during MUL: ignored; the tag matches the old H.
- **Reset mid-operation.** Assert `rst` during MUL with MUL_CYCLES = 4. Required: next cycle is NOKEY with all outputs at reset values. After reloading H, a fresh known-answer message gives the correct tag. Repeat the known-answer test with MUL_CYCLES = 1 and 16.
